// File: rtl/sp_result_writer_pkg.sv
// Shared parameters, FSM encoding and element-address helper for the scratchpad result writer.
// Purely declarative; no timing or flow control here.
package sp_result_writer_pkg;

  localparam int SP_NTARGETS = 4;
  localparam int DATA_WIDTH  = 32;
  localparam int BUS_WIDTH   = 64;
  localparam int MAX_DIM     = BUS_WIDTH / DATA_WIDTH;
  localparam int AW          = 2 * $clog2(MAX_DIM);
  localparam int DW          = $clog2(MAX_DIM) + 1;
  localparam int TW          = $clog2(SP_NTARGETS);
  localparam int NELEM       = MAX_DIM * MAX_DIM;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_DONE
  } state_e;

  function automatic logic [AW-1:0] elem_addr(input logic [AW/2-1:0] row,
                                               input logic [AW/2-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/sp_result_writer_if.sv
// Scratchpad port bundle: one element write or read per cycle, no backpressure.
// Read data is combinational from the scratchpad while we is low.
interface sp_result_writer_if;
  import sp_result_writer_pkg::*;

  logic                 we;
  logic [AW-1:0]        addr;
  logic [BUS_WIDTH-1:0] wr_data;
  logic [TW-1:0]        wr_target;
  logic [TW-1:0]        rd_target;
  logic [BUS_WIDTH-1:0] rd_data;

  modport master (output we, addr, wr_data, wr_target, rd_target, input rd_data);
  modport slave  (input we, addr, wr_data, wr_target, rd_target, output rd_data);

endinterface

// File: rtl/sp_result_writer_bias.sv
// Combinational bias adder: out-of-range elements are forced to zero and never carry.
// Zero latency, no flow control.
module sp_bias_adder
  import sp_result_writer_pkg::*;
(
  input  logic [BUS_WIDTH-1:0] operand_i,
  input  logic [BUS_WIDTH-1:0] bias_i,
  input  logic                 in_range_i,
  output logic [BUS_WIDTH-1:0] sum_o,
  output logic                 carry_o
);

  logic [BUS_WIDTH:0] full_sum;

  assign full_sum = {1'b0, operand_i} + {1'b0, bias_i};
  assign sum_o    = in_range_i ? full_sum[BUS_WIDTH-1:0] : '0;
  assign carry_o  = in_range_i & full_sum[BUS_WIDTH];

endmodule

// File: rtl/sp_result_writer.sv
// Serialises a captured result matrix into one scratchpad target, optionally adding a bias matrix.
// Plain: NELEM+1 cycles start-to-done, bias: 2*NELEM+1; start ignored while busy or done.
module sp_result_writer
  import sp_result_writer_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic                       mode_i,
  input  logic [TW-1:0]              target_i,
  input  logic [TW-1:0]              bias_target_i,
  input  logic [DW-1:0]              dim_n_i,
  input  logic [DW-1:0]              dim_m_i,
  input  logic [NELEM*BUS_WIDTH-1:0] result_i,
  sp_result_writer_if.master         sp,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       ovf_o
);

  state_e                     state_q, state_d;
  logic [AW-1:0]              k_q;
  logic [NELEM*BUS_WIDTH-1:0] res_q;
  logic                       mode_q;
  logic [TW-1:0]              tgt_q, btgt_q, rd_tgt_q;
  logic [DW-1:0]              dn_q, dm_q;
  logic [BUS_WIDTH-1:0]       bias_q;
  logic                       ovf_q;

  logic [AW/2-1:0]            row, col;
  logic                       in_range;
  logic [BUS_WIDTH-1:0]       elem, sum;
  logic                       carry;

  function automatic logic [DW-1:0] norm_dim(input logic [DW-1:0] d);
    return (d == '0 || d > DW'(MAX_DIM)) ? DW'(MAX_DIM) : d;
  endfunction

  assign row      = k_q[AW-1:AW/2];
  assign col      = k_q[AW/2-1:0];
  assign in_range = (DW'(row) < dn_q) && (DW'(col) < dm_q);
  assign elem     = res_q[32'(k_q)*BUS_WIDTH +: BUS_WIDTH];

  sp_bias_adder u_bias_adder (
    .operand_i  (elem),
    .bias_i     (mode_q ? bias_q : '0),
    .in_range_i (in_range),
    .sum_o      (sum),
    .carry_o    (carry)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_i) state_d = mode_i ? ST_RD : ST_WR;
      ST_RD:   state_d = ST_WR;
      ST_WR: begin
        if (k_q == AW'(NELEM-1)) state_d = ST_DONE;
        else if (mode_q)         state_d = ST_RD;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign sp.we        = (state_q == ST_WR);
  assign sp.addr      = (state_q == ST_RD || state_q == ST_WR) ? elem_addr(row, col) : '0;
  assign sp.wr_data   = (state_q == ST_WR) ? sum : '0;
  assign sp.wr_target = tgt_q;
  // Read target only follows the bias source while actually reading; otherwise it holds.
  assign sp.rd_target = (state_q == ST_RD) ? btgt_q : rd_tgt_q;
  assign busy_o       = (state_q == ST_RD) || (state_q == ST_WR);
  assign done_o       = (state_q == ST_DONE);
  assign ovf_o        = ovf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      res_q    <= '0;
      mode_q   <= 1'b0;
      tgt_q    <= '0;
      btgt_q   <= '0;
      rd_tgt_q <= '0;
      dn_q     <= '0;
      dm_q     <= '0;
      bias_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start_i) begin
        res_q  <= result_i;
        mode_q <= mode_i;
        tgt_q  <= target_i;
        btgt_q <= bias_target_i;
        dn_q   <= norm_dim(dim_n_i);
        dm_q   <= norm_dim(dim_m_i);
        k_q    <= '0;
        ovf_q  <= 1'b0;
      end
      if (state_q == ST_RD) begin
        bias_q   <= sp.rd_data;
        rd_tgt_q <= btgt_q;
      end
      if (state_q == ST_WR) begin
        k_q <= k_q + 1'b1;
        if (carry) ovf_q <= 1'b1;
      end
    end
  end

endmodule

// File: doc/sp_result_writer.md
Name: sp_result_writer

Overview:
- Upstream stage of the scratchpad. Captures a finished result matrix from the matmul core and serialises it into one scratchpad target, one element per write.
- Optional bias mode: each element is summed with the matching element of a source scratchpad target before write (C = A*B + Cbias).
- Drives the scratchpad's write_enable/address/data/write_target/mat_num inputs and consumes its read data.
- Gives the register/control layer a start/busy/done handshake.

Parameters:
- SP_NTARGETS, 4, number of scratchpad targets; target fields are 2 bits.
- DATA_WIDTH, 32, operand element width.
- BUS_WIDTH, 64, result element width; this is also the width of one scratchpad entry.
- MAX_DIM, BUS_WIDTH/DATA_WIDTH (localparam), maximum matrix dimension.
- AW, 2*$clog2(MAX_DIM) (localparam), scratchpad element address width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  single-cycle start request
- mode_i  in  1  0 = plain write, 1 = bias-add
- target_i  in  2  destination scratchpad target
- bias_target_i  in  2  bias source target, used when mode_i=1
- dim_n_i  in  $clog2(MAX_DIM)+1  valid rows, 1..MAX_DIM
- dim_m_i  in  $clog2(MAX_DIM)+1  valid columns, 1..MAX_DIM
- result_i  in  MAX_DIM*MAX_DIM*BUS_WIDTH  flattened result; element (r,c) sits at bits [(r*MAX_DIM+c)*BUS_WIDTH +: BUS_WIDTH]
- sp_rd_data_i  in  BUS_WIDTH  scratchpad read data (combinational, valid while sp_we_o=0)
- sp_we_o  out  1  scratchpad write enable
- sp_addr_o  out  AW  element address {row,col}
- sp_data_o  out  BUS_WIDTH  write data
- sp_wr_target_o  out  2  write target
- sp_rd_target_o  out  2  read target (scratchpad mat_num)
- busy_o  out  1  high from the cycle after an accepted start until DONE
- done_o  out  1  one-cycle completion pulse
- ovf_o  out  1  sticky bias-add carry-out flag

Behaviour:
- Reset (async, any state, including mid-operation): FSM to IDLE, all outputs 0, capture register cleared. A partially written matrix is left as is.
- FSM states: IDLE, RD, WR, DONE.
- IDLE, start_i=1:
  - latch result_i, mode_i, target_i, bias_target_i, dims;
  - element counter k=0;
  - clear ovf_o;
  - go to RD if mode_i=1, else WR.
- start_i while busy or in DONE: ignored, no effect.
- RD (bias mode only):
  - sp_we_o=0, sp_addr_o=k, sp_rd_target_o=bias_target;
  - sample sp_rd_data_i at the clock edge into a bias register;
  - go to WR.
- WR:
  - sp_we_o=1, sp_addr_o=k, sp_wr_target_o=target;
  - sp_data_o = elem(k) in plain mode, elem(k)+bias in bias mode.
  - The sum is truncated to BUS_WIDTH; the carry sets ovf_o (sticky until the next accepted start).
  - If k==MAX_DIM*MAX_DIM-1, go to DONE. Otherwise k+1, then to RD (bias) or stay in WR (plain).
- Out-of-range elements: row>=dim_n or col>=dim_m are written as 0 (and bias is ignored), so stale data is cleared. Every element of the target is always written.
- DONE: done_o=1 for exactly one cycle, busy_o=0, then IDLE.
- k addresses elements row-major: row=k[AW-1:AW/2], col=k[AW/2-1:0].
- Outside WR: sp_we_o=0 and sp_data_o=0.
- Outside RD: sp_rd_target_o holds its last value.
- Latency from the start edge to done_o:
  - plain: MAX_DIM^2+1 cycles;
  - bias: 2*MAX_DIM^2+1 cycles.
- Same-target case (bias_target == target): legal. Each element is read before its own write, and the counter never revisits an element.
- dim 0 or dim > MAX_DIM: treated as MAX_DIM.
- An external scratchpad writer during busy_o is a system error; it is not arbitrated here.

Decomposition:
- Shared package: SP_NTARGETS, DATA_WIDTH, BUS_WIDTH, MAX_DIM, AW; FSM state encoding typedef; element-index helper function (row,col -> address).
- One natural sub-module: sp_bias_adder. It is combinational: operand, bias and in-range flag in; sum and carry out.

Test Plan:
- Plain write, defaults (MAX_DIM=2, dims 2x2), result elements {1,2,3,4}, target 1 -> writes to addresses 0..3 on consecutive cycles with data 1,2,3,4; done_o on cycle 5; no reads driven.
- Bias mode, bias target 2 preloaded with {10,20,30,40}, result {1,2,3,4}, target 3 -> RD/WR alternate; writes 11,22,33,44; done_o on cycle 9; ovf_o=0.
- Overflow: bias element 0xFFFF_FFFF_FFFF_FFFF plus result 2 -> written 1, ovf_o=1 and still 1 after done_o; the next start clears it.
- Dims 1x2, result {5,6,7,8} -> addresses 0..3 receive 5,6,0,0.
- start_i asserted again mid-operation -> ignored, same write sequence; then rst_ni low during WR at k=2 -> all outputs 0 immediately, a new start begins from k=0.
- Same-target bias (target=bias=0, preload {1,1,1,1}, result {1,1,1,1}) -> target 0 ends as {2,2,2,2}.
